// File: rtl/hsstl_rate_chg_seq_v1_0_if.sv
// Control bundle between a rate-change requester (master) and the HSSTL TX rate-change sequencer (slave).
interface hsstl_rate_chg_seq_v1_0_if;
  logic       tx_rst_done;
  logic       pll_lock_deb;
  logic       rate_chg_req;
  logic       rate_target;
  logic       rate_chg_ack;
  logic       rate_cur;
  logic       busy;
  logic       timeout_err;
  logic       P_RATE_CHG_TXPCLK_ON;
  logic [2:0] P_PMA_TX_RATE;
  logic       P_PMA_TX_RST;
  logic       P_PCS_TX_RST;

  modport master (
    output tx_rst_done, pll_lock_deb, rate_chg_req, rate_target,
    input  rate_chg_ack, rate_cur, busy, timeout_err,
           P_RATE_CHG_TXPCLK_ON, P_PMA_TX_RATE, P_PMA_TX_RST, P_PCS_TX_RST
  );

  modport slave (
    input  tx_rst_done, pll_lock_deb, rate_chg_req, rate_target,
    output rate_chg_ack, rate_cur, busy, timeout_err,
           P_RATE_CHG_TXPCLK_ON, P_PMA_TX_RATE, P_PMA_TX_RST, P_PCS_TX_RST
  );
endinterface

// File: rtl/hsstl_rate_chg_seq_v1_0.sv
// HSSTL TX rate-change sequencer: gates PCLK, pulses PMA/PCS TX resets and commits the new rate code.
// Optional request watchdog with ERR state: define HSSTL_RATE_CHG_TIMEOUT_EN.
module hsstl_rate_chg_seq_v1_0 #(
  parameter int PCLK_OFF_CYCLES = 16,
  parameter int RST_HOLD_CYCLES = 32,
  parameter int SETTLE_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int CNTR_WIDTH      = 13
) (
  input logic                      clk,
  input logic                      rst_n,
  hsstl_rate_chg_seq_v1_0_if.slave bus
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PCLK_OFF    = 3'd1;
  localparam logic [2:0] S_RST_ASSERT  = 3'd2;
  localparam logic [2:0] S_RATE_SET    = 3'd3;
  localparam logic [2:0] S_RST_RELEASE = 3'd4;
  localparam logic [2:0] S_SETTLE      = 3'd5;
  localparam logic [2:0] S_DONE        = 3'd6;
`ifdef HSSTL_RATE_CHG_TIMEOUT_EN
  localparam logic [2:0] S_ERR         = 3'd7;
`endif

  localparam logic [CNTR_WIDTH-1:0] PCLK_OFF_LAST = CNTR_WIDTH'(PCLK_OFF_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] RST_HOLD_LAST = CNTR_WIDTH'(RST_HOLD_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] SETTLE_LAST   = CNTR_WIDTH'(SETTLE_CYCLES - 1);
  localparam int                    CNT_MAX       = (1 << CNTR_WIDTH) - 1;

  if (PCLK_OFF_CYCLES < 1 || PCLK_OFF_CYCLES > CNT_MAX ||
      RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > CNT_MAX ||
      SETTLE_CYCLES   < 1 || SETTLE_CYCLES   > CNT_MAX ||
      TIMEOUT_CYCLES  < 1 || TIMEOUT_CYCLES  > CNT_MAX) begin : g_param_check
    $error("hsstl_rate_chg_seq_v1_0: cycle parameter outside 1..2^CNTR_WIDTH-1");
  end

  function automatic logic [2:0] rate_code(input logic rate);
    return rate ? 3'b001 : 3'b010;
  endfunction

  logic [2:0]            state_reg, state_next;
  logic [CNTR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  armed_reg, armed_next;
  logic                  tgt_reg;
  logic                  rate_cur_reg;
  logic [2:0]            pma_rate_reg;
  logic                  accept;
  logic                  ack;
  logic                  in_flight;
  logic                  timeout_hit;

`ifdef HSSTL_RATE_CHG_TIMEOUT_EN
  assign ack = (state_reg == S_DONE) || (state_reg == S_ERR);
`else
  assign ack = (state_reg == S_DONE);
`endif
  // States that are still working toward DONE; only these can abort or time out.
  assign in_flight = (state_reg != S_IDLE) && !ack;
  assign accept    = (state_reg == S_IDLE) && bus.rate_chg_req && bus.tx_rst_done && armed_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:        if (accept) state_next = (bus.rate_target == rate_cur_reg) ? S_DONE : S_PCLK_OFF;
      S_PCLK_OFF:    if (cnt_reg == PCLK_OFF_LAST) state_next = S_RST_ASSERT;
      S_RST_ASSERT:  if (cnt_reg == RST_HOLD_LAST) state_next = S_RATE_SET;
      S_RATE_SET:    state_next = S_RST_RELEASE;
      S_RST_RELEASE: if (bus.pll_lock_deb) state_next = S_SETTLE;
      S_SETTLE:      if (cnt_reg == SETTLE_LAST) state_next = S_DONE;
      default:       state_next = S_IDLE;
    endcase
`ifdef HSSTL_RATE_CHG_TIMEOUT_EN
    if (timeout_hit) state_next = S_ERR;
`endif
    if (in_flight && !bus.tx_rst_done) state_next = S_IDLE;
  end

  assign cnt_next = (state_next != state_reg) ? '0 : cnt_reg + 1'b1;

  always_comb begin
    armed_next = armed_reg;
    if (accept || ack)          armed_next = 1'b0;
    else if (!bus.rate_chg_req) armed_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      armed_reg    <= 1'b1;
      tgt_reg      <= 1'b0;
      rate_cur_reg <= 1'b0;
      pma_rate_reg <= 3'b010;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      armed_reg <= armed_next;
      if (accept) tgt_reg <= bus.rate_target;
      if (state_reg == S_RATE_SET) begin
        rate_cur_reg <= tgt_reg;
        pma_rate_reg <= rate_code(tgt_reg);
      end
    end
  end

`ifdef HSSTL_RATE_CHG_TIMEOUT_EN
  localparam logic [CNTR_WIDTH-1:0] WD_LAST = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNTR_WIDTH-1:0] wd_reg, wd_next;
  logic                  timeout_err_reg;

  // The first busy cycle reads 1, so ERR occupies busy cycle TIMEOUT_CYCLES.
  assign timeout_hit = in_flight && (wd_reg == WD_LAST);

  always_comb begin
    wd_next = wd_reg;
    if (accept)         wd_next = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    else if (in_flight) wd_next = wd_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_reg          <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wd_reg <= wd_next;
      if (accept)                               timeout_err_reg <= 1'b0;
      else if (timeout_hit && bus.tx_rst_done)  timeout_err_reg <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_reg;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    bus.P_RATE_CHG_TXPCLK_ON = 1'b1;
    bus.P_PMA_TX_RST         = 1'b0;
    bus.P_PCS_TX_RST         = 1'b0;
    case (state_reg)
      S_PCLK_OFF: bus.P_RATE_CHG_TXPCLK_ON = 1'b0;
      S_RST_ASSERT, S_RATE_SET: begin
        bus.P_RATE_CHG_TXPCLK_ON = 1'b0;
        bus.P_PMA_TX_RST         = 1'b1;
        bus.P_PCS_TX_RST         = 1'b1;
      end
      S_RST_RELEASE: begin
        bus.P_RATE_CHG_TXPCLK_ON = 1'b0;
        bus.P_PCS_TX_RST         = 1'b1;
      end
      S_SETTLE: bus.P_PCS_TX_RST = 1'b1;
      default: ;
    endcase
  end

  assign bus.rate_chg_ack  = ack;
  assign bus.busy          = (state_reg != S_IDLE);
  assign bus.rate_cur      = rate_cur_reg;
  assign bus.P_PMA_TX_RATE = pma_rate_reg;

endmodule

// File: tb/tb_hsstl_rate_chg_seq_v1_0.sv
// Directed bench for hsstl_rate_chg_seq_v1_0: timeline model checked every cycle plus literal scenario checks.
module tb_hsstl_rate_chg_seq_v1_0;
  localparam int P  = 16;
  localparam int R  = 32;
  localparam int S  = 64;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsstl_rate_chg_seq_v1_0_if bus();

  hsstl_rate_chg_seq_v1_0 #(
    .PCLK_OFF_CYCLES(P), .RST_HOLD_CYCLES(R), .SETTLE_CYCLES(S),
    .TIMEOUT_CYCLES(TO), .CNTR_WIDTH(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: a request is a timeline of busy cycles numbered from 1 after the accepting edge.
  bit m_busy = 0, m_final = 0, m_err = 0, m_tgt = 0, m_rate = 0, m_armed = 1, m_terr = 0;
  bit m_acc, m_closing, m_hit_to;
  int m_age = 0, m_lock_at = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_final = 0; m_err = 0; m_rate = 0; m_armed = 1; m_terr = 0;
      m_age = 0; m_lock_at = 0;
    end else begin
      m_closing = m_busy && m_final;
      m_acc     = !m_busy && bus.rate_chg_req && bus.tx_rst_done && m_armed;
      if (m_acc || m_closing)   m_armed = 0;
      else if (!bus.rate_chg_req) m_armed = 1;
      if (m_acc) begin
        m_busy = 1; m_age = 1; m_tgt = bus.rate_target; m_final = (bus.rate_target == m_rate);
        m_err = 0; m_terr = 0; m_lock_at = 0;
      end else if (m_busy) begin
        if (m_final) m_busy = 0;
        else begin
          if (m_age == P + R + 1) m_rate = m_tgt;
          if (!bus.tx_rst_done) m_busy = 0;
          else begin
            if (m_age >= P + R + 2 && m_lock_at == 0 && bus.pll_lock_deb) m_lock_at = m_age + 1;
            m_age++;
            m_hit_to = 0;
`ifdef HSSTL_RATE_CHG_TIMEOUT_EN
            m_hit_to = (m_age == TO);
`endif
            if (m_hit_to) begin
              m_final = 1; m_err = 1; m_terr = 1;
            end else if (m_lock_at != 0 && m_age == m_lock_at + S) m_final = 1;
          end
        end
      end
    end
  end

  logic e_pclk, e_pma, e_pcs, e_ack;
  initial forever begin
    @(negedge clk);
    e_pclk = 1; e_pma = 0; e_pcs = 0; e_ack = 0;
    if (m_busy) begin
      if (m_final) e_ack = 1;
      else if (m_age <= P) e_pclk = 0;
      else if (m_age <= P + R + 1) begin e_pclk = 0; e_pma = 1; e_pcs = 1; end
      else if (m_lock_at == 0 || m_age < m_lock_at) begin e_pclk = 0; e_pcs = 1; end
      else e_pcs = 1;
    end
    check("cyc_pclk_on", bus.P_RATE_CHG_TXPCLK_ON, e_pclk);
    check("cyc_pma_rst", bus.P_PMA_TX_RST, e_pma);
    check("cyc_pcs_rst", bus.P_PCS_TX_RST, e_pcs);
    check("cyc_ack", bus.rate_chg_ack, e_ack);
    check("cyc_busy", bus.busy, m_busy);
    check("cyc_rate_cur", bus.rate_cur, m_rate);
    check("cyc_rate_code", bus.P_PMA_TX_RATE, m_rate ? 3'b001 : 3'b010);
    check("cyc_timeout_err", bus.timeout_err, m_terr);
  end

  // Edge monitor for the literal scenario measurements.
  logic p_pclk = 1, p_pma = 0, p_pcs = 0, p_ack = 0;
  int n_pclk_fall, n_pclk_rise, n_pma_rise, n_pcs_rise, n_ack, n_ack_hi;
  int t_pclk_fall, t_pclk_rise, t_pma_rise, t_pma_fall, t_pcs_fall, t_ack;

  initial forever begin
    @(negedge clk);
    if (p_pclk && !bus.P_RATE_CHG_TXPCLK_ON) begin n_pclk_fall++; t_pclk_fall = cyc; end
    if (!p_pclk && bus.P_RATE_CHG_TXPCLK_ON) begin n_pclk_rise++; t_pclk_rise = cyc; end
    if (!p_pma && bus.P_PMA_TX_RST) begin n_pma_rise++; t_pma_rise = cyc; end
    if (p_pma && !bus.P_PMA_TX_RST) t_pma_fall = cyc;
    if (!p_pcs && bus.P_PCS_TX_RST) n_pcs_rise++;
    if (p_pcs && !bus.P_PCS_TX_RST) t_pcs_fall = cyc;
    if (!p_ack && bus.rate_chg_ack) begin n_ack++; t_ack = cyc; end
    if (bus.rate_chg_ack) n_ack_hi++;
    p_pclk = bus.P_RATE_CHG_TXPCLK_ON; p_pma = bus.P_PMA_TX_RST;
    p_pcs = bus.P_PCS_TX_RST; p_ack = bus.rate_chg_ack;
  end

  task automatic mon_clear();
    n_pclk_fall = 0; n_pclk_rise = 0; n_pma_rise = 0; n_pcs_rise = 0; n_ack = 0; n_ack_hi = 0;
    t_pclk_fall = 0; t_pclk_rise = 0; t_pma_rise = 0; t_pma_fall = 0; t_pcs_fall = 0; t_ack = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int budget, input string name);
    int i;
    i = 0;
    while (n_ack == 0 && i < budget) begin step(1); i++; end
    check({name, "_ack_seen"}, 32'(n_ack != 0), 1);
  endtask

  int req_cyc;

  initial begin
    bus.rate_chg_req = 0; bus.rate_target = 0; bus.tx_rst_done = 1; bus.pll_lock_deb = 1;
    mon_clear();
    step(3);
    rst_n = 1;
    step(1);
    check("rst_rate_cur", bus.rate_cur, 0);
    check("rst_rate_code", bus.P_PMA_TX_RATE, 3'b010);
    check("rst_pclk_on", bus.P_RATE_CHG_TXPCLK_ON, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_resets", {bus.P_PMA_TX_RST, bus.P_PCS_TX_RST}, 2'b00);

    // A: full 0 -> 1 change, request then held 50 cycles after the ack.
    mon_clear(); req_cyc = cyc;
    bus.rate_target = 1; bus.rate_chg_req = 1;
    wait_ack(300, "A");
    check("A_pclk_off_len", t_pma_rise - t_pclk_fall, P);
    check("A_pma_rst_len", t_pma_fall - t_pma_rise, R + 1);
    check("A_settle_len", t_pcs_fall - t_pclk_rise, S);
    check("A_total", t_ack - req_cyc, P + R + 2 + 1 + S);
    step(50);
    check("A_ack_count_held", n_ack, 1);
    check("A_ack_width", n_ack_hi, 1);
    check("A_rate_cur", bus.rate_cur, 1);
    check("A_rate_code", bus.P_PMA_TX_RATE, 3'b001);
    $display("txn A: rate 0->1 ack at +%0d cycles, acks while held %0d", t_ack - req_cyc, n_ack);
    bus.rate_chg_req = 0;
    step(2);

    // B: target equals current rate; accepted only after the drop above.
    mon_clear(); req_cyc = cyc;
    bus.rate_target = 1; bus.rate_chg_req = 1;
    wait_ack(10, "B");
    check("B_ack_latency", t_ack - req_cyc, 1);
    check("B_no_pclk_gate", n_pclk_fall, 0);
    check("B_no_pma_rst", n_pma_rise, 0);
    check("B_no_pcs_rst", n_pcs_rise, 0);
    $display("txn B: same-rate request ack at +%0d cycles", t_ack - req_cyc);
    bus.rate_chg_req = 0;
    step(2);

    // D: rst_n asserted mid RST_ASSERT during a 1 -> 0 change.
    mon_clear();
    bus.rate_target = 0; bus.rate_chg_req = 1;
    for (int i = 0; i < 60 && n_pma_rise == 0; i++) step(1);
    check("D_reached_rst_assert", n_pma_rise, 1);
    step(5);
    #1 rst_n = 0;
    #1;
    check("D_async_pclk_on", bus.P_RATE_CHG_TXPCLK_ON, 1);
    check("D_async_resets", {bus.P_PMA_TX_RST, bus.P_PCS_TX_RST}, 2'b00);
    check("D_async_ack_busy", {bus.rate_chg_ack, bus.busy}, 2'b00);
    check("D_async_rate_cur", bus.rate_cur, 0);
    check("D_async_rate_code", bus.P_PMA_TX_RATE, 3'b010);
    check("D_async_timeout_err", bus.timeout_err, 0);
    $display("txn D: async reset mid reset-hold, busy=%0b rate_cur=%0b", bus.busy, bus.rate_cur);
    bus.rate_chg_req = 0;
    step(2);
    rst_n = 1;
    step(2);

    // C: 0 -> 1 change aborted by tx_rst_done falling during SETTLE.
    mon_clear();
    bus.rate_target = 1; bus.rate_chg_req = 1;
    for (int i = 0; i < 120 && n_pclk_rise == 0; i++) step(1);
    check("C_reached_settle", n_pclk_rise, 1);
    step(10);
    bus.tx_rst_done = 0;
    step(1);
    check("C_idle_next", bus.busy, 0);
    check("C_resets_off", {bus.P_PMA_TX_RST, bus.P_PCS_TX_RST}, 2'b00);
    check("C_pclk_on", bus.P_RATE_CHG_TXPCLK_ON, 1);
    check("C_rate_kept", bus.rate_cur, 1);
    check("C_code_kept", bus.P_PMA_TX_RATE, 3'b001);
    step(5);
    check("C_no_ack", n_ack, 0);
    $display("txn C: abort in settle, busy=%0b rate_cur=%0b acks=%0d", bus.busy, bus.rate_cur, n_ack);
    bus.tx_rst_done = 1; bus.rate_chg_req = 0;
    step(2);

    // E: 1 -> 0 change with PLL lock never arriving.
    mon_clear(); req_cyc = cyc;
    bus.pll_lock_deb = 0; bus.rate_target = 0; bus.rate_chg_req = 1;
`ifdef HSSTL_RATE_CHG_TIMEOUT_EN
    wait_ack(TO + 100, "E");
    check("E_timeout_latency", t_ack - req_cyc, TO);
    check("E_timeout_err_set", bus.timeout_err, 1);
    check("E_rate_committed", bus.rate_cur, 0);
    $display("txn E: watchdog ack at +%0d cycles, timeout_err=%0b", t_ack - req_cyc, bus.timeout_err);
    bus.rate_chg_req = 0; bus.pll_lock_deb = 1;
    step(3);
    check("E_timeout_err_sticky", bus.timeout_err, 1);
    mon_clear();
    bus.rate_chg_req = 1;
    wait_ack(10, "E2");
    check("E2_timeout_err_clear", bus.timeout_err, 0);
    $display("txn E2: same-rate request after timeout, timeout_err=%0b", bus.timeout_err);
    bus.rate_chg_req = 0;
    step(2);
`else
    step(TO + 100);
    check("E_still_busy", bus.busy, 1);
    check("E_no_ack", n_ack, 0);
    check("E_no_timeout_err", bus.timeout_err, 0);
    $display("txn E: no watchdog, busy=%0b after %0d cycles", bus.busy, cyc - req_cyc);
    bus.tx_rst_done = 0;
    step(1);
    check("E_abort_idle", bus.busy, 0);
    bus.tx_rst_done = 1; bus.rate_chg_req = 0; bus.pll_lock_deb = 1;
    step(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
